// File: rtl/tt_seq_onehot_decoder.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with a prescaled up/down scan engine.
// Optional `SKIP_MASK_EN adds skip_mask: scan steps pass over masked indices.
module tt_seq_onehot_decoder #(
    parameter  int SEL_W = 2,
    parameter  int DIV_W = 8,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [SEL_W-1:0] sel_in,
    input  logic [DIV_W-1:0] div_in,
`ifdef SKIP_MASK_EN
    input  logic [OUT_W-1:0] skip_mask,
`endif
    output logic [OUT_W-1:0] dec_out,
    output logic [SEL_W-1:0] idx_out,
    output logic             valid,
    output logic             wrap
);

    localparam logic [1:0] MODE_DIR  = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DN   = 2'b10;

    logic [SEL_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic [OUT_W-1:0] dec_q, dec_d;
    logic [1:0]       mode_q, mode_d;

    logic [SEL_W-1:0] step_idx;
    logic             step_wrap;
    logic             step_ok;
    logic             dn;
    logic             blank;

    assign dn = (mode == MODE_DN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            pre_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            dec_q   <= '0;
            mode_q  <= MODE_DIR;
        end else begin
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            dec_q   <= dec_d;
            mode_q  <= mode_d;
        end
    end

`ifdef SKIP_MASK_EN
    int cand;

    // Nearest unmasked index in the scan direction; k == OUT_W revisits idx itself.
    always_comb begin
        cand      = 0;
        step_idx  = idx_q;
        step_wrap = 1'b0;
        step_ok   = 1'b0;
        for (int k = 1; k <= OUT_W; k++) begin
            cand = dn ? int'(idx_q) - k : int'(idx_q) + k;
            if (!step_ok && !skip_mask[SEL_W'((cand + OUT_W) % OUT_W)]) begin
                step_ok   = 1'b1;
                step_idx  = SEL_W'((cand + OUT_W) % OUT_W);
                step_wrap = (cand < 0) || (cand >= OUT_W);
            end
        end
    end

    assign blank = &skip_mask;
`else
    always_comb begin
        step_ok   = 1'b1;
        step_idx  = dn ? idx_q - 1'b1 : idx_q + 1'b1;
        step_wrap = dn ? (idx_q == '0) : (idx_q == SEL_W'(OUT_W - 1));
    end

    assign blank = 1'b0;
`endif

    // Next-state: load beats a mode-change clear, which beats a scan step
    always_comb begin
        idx_d   = idx_q;
        pre_d   = pre_q;
        valid_d = valid_q;
        mode_d  = mode_q;
        dec_d   = dec_q;
        wrap_d  = 1'b0;
        if (ena) begin
            mode_d = mode;
            if (load) begin
                idx_d   = sel_in;
                pre_d   = '0;
                valid_d = 1'b1;
            end else if (mode != mode_q) begin
                pre_d = '0;
            end else if (mode == MODE_UP || mode == MODE_DN) begin
                if (pre_q >= div_in) begin
                    pre_d = '0;
                    if (step_ok) begin
                        idx_d   = step_idx;
                        valid_d = 1'b1;
                        wrap_d  = step_wrap;
                    end
                end else begin
                    pre_d = pre_q + DIV_W'(1);
                end
            end else if (mode == MODE_DIR) begin
                pre_d = '0;
            end
            dec_d = (valid_d && !blank) ? (OUT_W'(1) << idx_d) : '0;
        end
    end

    // Outputs straight from registers
    always_comb begin
        dec_out = dec_q;
        idx_out = idx_q;
        valid   = valid_q;
        wrap    = wrap_q;
    end

endmodule

// File: tb/tb_tt_seq_onehot_decoder.sv
// Directed self-checking bench for tt_seq_onehot_decoder (SEL_W=2, DIV_W=8).
module tb_tt_seq_onehot_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [1:0] mode;
    logic       load;
    logic [1:0] sel_in;
    logic [7:0] div_in;
    logic [3:0] dec_out;
    logic [1:0] idx_out;
    logic       valid;
    logic       wrap;
`ifdef SKIP_MASK_EN
    logic [3:0] skip_mask = 4'b0000;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tt_seq_onehot_decoder #(.SEL_W(2), .DIV_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .mode    (mode),
        .load    (load),
        .sel_in  (sel_in),
        .div_in  (div_in),
`ifdef SKIP_MASK_EN
        .skip_mask(skip_mask),
`endif
        .dec_out (dec_out),
        .idx_out (idx_out),
        .valid   (valid),
        .wrap    (wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] d, input logic [1:0] i,
                             input logic v, input logic w);
        chk({tag, ".dec"},   32'(dec_out), 32'(d));
        chk({tag, ".idx"},   32'(idx_out), 32'(i));
        chk({tag, ".valid"}, 32'(valid),   32'(v));
        chk({tag, ".wrap"},  32'(wrap),    32'(w));
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; mode = 2'b00; load = 1'b0; sel_in = '0; div_in = '0;
        tick(); tick();
        chk_state("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1; ena = 1'b1;
        tick();
        chk_state("pre_load", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Direct load
        load = 1'b1; sel_in = 2'd2;
        tick();
        load = 1'b0;
        chk_state("load2", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Scan up, div 2: first edge is a mode change, then a step every 3 cycles
        mode = 2'b01; div_in = 8'd2;
        tick(); chk("up.e1", 32'(dec_out), 32'h4);
        tick(); chk("up.e2", 32'(dec_out), 32'h4);
        tick(); chk("up.e3", 32'(dec_out), 32'h4);
        tick(); chk_state("up.step3", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick(); chk("up.e5", 32'(dec_out), 32'h8);
        tick(); chk_state("up.e6", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick(); chk_state("up.wrap", 4'b0001, 2'd0, 1'b1, 1'b1);
        tick(); chk_state("up.after_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Scan down, div 0, from idx 1
        mode = 2'b10; div_in = 8'd0; load = 1'b1; sel_in = 2'd1;
        tick(); load = 1'b0;
        chk_state("dn.load1", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick(); chk_state("dn.s0", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick(); chk_state("dn.wrap", 4'b1000, 2'd3, 1'b1, 1'b1);
        tick(); chk_state("dn.s2", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Scan up mid-count, then hold with ena toggling and a load ignored while disabled
        mode = 2'b01; div_in = 8'd4; load = 1'b1; sel_in = 2'd0;
        tick(); load = 1'b0;
        tick(); tick();
        mode = 2'b11;
        tick(); chk_state("hold.enter", 4'b0001, 2'd0, 1'b1, 1'b0);
        load = 1'b1; sel_in = 2'd1;
        ena = 1'b0; tick(); chk("hold.ena0_load", 32'(idx_out), 32'd0);
        load = 1'b0;
        ena = 1'b1; tick(); chk("hold.c2", 32'(dec_out), 32'h1);
        ena = 1'b0; tick(); chk("hold.c3", 32'(idx_out), 32'd0);
        ena = 1'b1; tick(); chk("hold.c4", 32'(dec_out), 32'h1);
        ena = 1'b0; tick(); chk("hold.c5", 32'(idx_out), 32'd0);
        ena = 1'b1; load = 1'b1; sel_in = 2'd3;
        tick(); load = 1'b0;
        chk_state("hold.load3", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Load clears the prescaler mid-count
        mode = 2'b01; div_in = 8'd3;
        tick(); tick(); tick();
        load = 1'b1; sel_in = 2'd3;
        tick(); load = 1'b0;
        tick(); chk("preclr.e5", 32'(dec_out), 32'h8);
        tick(); chk("preclr.e6", 32'(dec_out), 32'h8);
        tick(); chk("preclr.e7", 32'(dec_out), 32'h8);
        tick(); chk_state("preclr.step", 4'b0001, 2'd0, 1'b1, 1'b1);

        // Lowering div below the prescaler forces a step on the next cycle
        tick(); tick();
        div_in = 8'd1;
        tick(); chk_state("divlow", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Asynchronous reset between edges
        div_in = 8'd0;
        #2 rst_n = 1'b0;
        #1 chk_state("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1; mode = 2'b01; div_in = 8'd1;
        tick(); chk_state("rel.e1", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick(); chk("rel.e2", 32'(dec_out), 32'h0);
        tick(); chk_state("rel.step", 4'b0010, 2'd1, 1'b1, 1'b0);

`ifdef SKIP_MASK_EN
        skip_mask = 4'b0110; div_in = 8'd0; load = 1'b1; sel_in = 2'd0;
        tick(); load = 1'b0;
        chk("mask.load0", 32'(dec_out), 32'h1);
        tick(); chk_state("mask.s3", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick(); chk_state("mask.wrap", 4'b0001, 2'd0, 1'b1, 1'b1);
        skip_mask = 4'b1111;
        tick(); chk_state("mask.all", 4'b0000, 2'd0, 1'b1, 1'b0);
        tick(); chk("mask.all_idx", 32'(idx_out), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
